// File: rtl/seg7_pattern_decoder.sv
// Reads a seven-segment bus back into the fabric: synchronize, debounce, decode to hex, offer on VALID/READY.
// Optional feature macro SEG7_DEC_ERRCNT_EN adds ERR_COUNT, a saturating count of accepted error offers.
module seg7_pattern_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       CLOCK_50,
   input  logic       RST_N,
   input  logic [0:6] HEX_IN,
   input  logic       READY,
   output logic       VALID,
   output logic [3:0] VALUE,
   output logic       BLANK,
   output logic       ERR
`ifdef SEG7_DEC_ERRCNT_EN
   ,
   output logic [7:0] ERR_COUNT
`endif
);

   typedef enum logic {IDLE, OFFER} state_t;

   localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
   localparam logic [6:0] RAW_UNLIT = ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [6:0] rawSeg;
   logic [6:0] sync1_q, sync2_q;
   logic [6:0] segS;
   logic [6:0] cur_q;
   logic [7:0] cnt_q, cnt_d;
   logic       stable;
   state_t     state_q, state_d;
   logic [6:0] last_q, last_d;
   logic [6:0] offer_q, offer_d;
   logic       valid_q, valid_d;
   logic [3:0] value_q, value_d;
   logic       blank_q, blank_d;
   logic       err_q, err_d;
   logic [5:0] decS;

   // Returns {err, blank, value} for a lit=1 pattern with bit i = segment i.
   function automatic logic [5:0] decode(input logic [6:0] p);
      logic [5:0] r;
      r = 6'b10_0000;
      case (p)
         7'h3F: r = 6'h00;
         7'h06: r = 6'h01;
         7'h5B: r = 6'h02;
         7'h4F: r = 6'h03;
         7'h66: r = 6'h04;
         7'h6D: r = 6'h05;
         7'h7D: r = 6'h06;
         7'h07: r = 6'h07;
         7'h7F: r = 6'h08;
         7'h6F: r = 6'h09;
         7'h77: r = 6'h0A;
         7'h7C: r = 6'h0B;
         7'h39: r = 6'h0C;
         7'h5E: r = 6'h0D;
         7'h79: r = 6'h0E;
         7'h71: r = 6'h0F;
         7'h00: r = 6'b01_0000;
         default: r = 6'b10_0000;
      endcase
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < 7; i++) begin
         rawSeg[i] = HEX_IN[i];
      end
   end

   assign segS = ACTIVE_LOW ? ~sync2_q : sync2_q;
   assign decS = decode(segS);

   // cnt_d counts consecutive equal samples including the current one, so stable can act this edge.
   always_comb begin
      cnt_d = cnt_q;
      if (segS != cur_q) begin
         cnt_d = 8'd1;
      end else if (cnt_q < STABLE_C) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign stable = (cnt_d == STABLE_C);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      offer_d = offer_q;
      valid_d = valid_q;
      value_d = value_q;
      blank_d = blank_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (stable && (segS != last_q)) begin
               offer_d = segS;
               {err_d, blank_d, value_d} = decS;
               valid_d = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (READY) begin
               last_d = offer_q;
               if (stable && (segS != offer_q)) begin
                  offer_d = segS;
                  {err_d, blank_d, value_d} = decS;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= RAW_UNLIT;
         sync2_q <= RAW_UNLIT;
         cur_q   <= '0;
         cnt_q   <= '0;
         state_q <= IDLE;
         last_q  <= '0;
         offer_q <= '0;
         valid_q <= 1'b0;
         value_q <= '0;
         blank_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= rawSeg;
         sync2_q <= sync1_q;
         cur_q   <= segS;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         last_q  <= last_d;
         offer_q <= offer_d;
         valid_q <= valid_d;
         value_q <= value_d;
         blank_q <= blank_d;
         err_q   <= err_d;
      end
   end

   assign VALID = valid_q;
   assign VALUE = value_q;
   assign BLANK = blank_q;
   assign ERR   = err_q;

`ifdef SEG7_DEC_ERRCNT_EN
   logic [7:0] errCnt_q;

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         errCnt_q <= '0;
      end else if (valid_q && READY && err_q && (errCnt_q != 8'hFF)) begin
         errCnt_q <= errCnt_q + 8'd1;
      end
   end

   assign ERR_COUNT = errCnt_q;
`endif

endmodule
